pipelined_regfile_fwd: RTL and testbench

- Parametrised register file with registered ID/EXE read stage for the 5-stage pipeline datapath.
- Generalises the fixed-width register file with configurable data width, register count and read-port count.
- Adds EXE/MEM and MEM/WB operand forwarding, same-cycle write-through and load-use hazard detection.
- Sits between decode and execute; drives ALU operands and the stall request to PC/IF/ID.

---
 rtl/pipelined_regfile_fwd.sv | 147 ++++++++++++++
 tb/tb_pipelined_regfile_fwd.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_regfile_fwd.sv
// Parametrised register file with registered ID/EXE read stage, EXE/MEM and MEM/WB
// forwarding, write-through and load-use stall. Optional counters: PIPE_REGFILE_PERF_CNT_EN.
module pipelined_regfile_fwd #(
    parameter int DW       = 16,
    parameter int NREG     = 16,
    parameter int NRP      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRP*AW-1:0] raddr,
    input  logic [NRP-1:0]    ren,
    input  logic [AW-1:0]     id_waddr,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic [AW-1:0]     mem_waddr,
    input  logic              mem_we,
    input  logic [DW-1:0]     mem_data,
    input  logic [AW-1:0]     wb_waddr,
    input  logic              wb_we,
    input  logic [DW-1:0]     wb_data,
    output logic [NRP*DW-1:0] rdata_ID_EXE,
    output logic [AW-1:0]     waddr_ID_EXE,
    output logic              we_ID_EXE,
    output logic              load_ID_EXE,
    output logic              stall
`ifdef PIPE_REGFILE_PERF_CNT_EN
    ,
    output logic [31:0]       fwd_count,
    output logic [31:0]       stall_count
`endif
);

    logic [DW-1:0]     r_regs [NREG];
    logic [NRP*DW-1:0] r_rdata;
    logic [AW-1:0]     r_waddr;
    logic              r_we;
    logic              r_load;

    logic [NRP*DW-1:0] w_rdata;
    logic [NRP-1:0]    w_hit;
    logic              w_zero_en;
    logic              w_wb_write;
    logic              w_stall;

    assign w_zero_en  = (ZERO_REG != 0);
    assign w_wb_write = wb_we && !(w_zero_en && wb_waddr == '0);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it latched.
    always_comb begin
        logic [AW-1:0] w_addr;
        w_rdata = '0;
        w_hit   = '0;
        w_addr  = '0;
        for (int p = 0; p < NRP; p++) begin
            w_addr = raddr[p*AW +: AW];
            if (w_zero_en && w_addr == '0)
                w_rdata[p*DW +: DW] = '0;
            else if (mem_we && mem_waddr == w_addr)
                w_rdata[p*DW +: DW] = mem_data;
            else if (wb_we && wb_waddr == w_addr)
                w_rdata[p*DW +: DW] = wb_data;
            else
                w_rdata[p*DW +: DW] = r_regs[w_addr];
            w_hit[p] = ren[p] && (w_addr == r_waddr) && !(w_zero_en && w_addr == '0);
        end
    end

    // Load in EXE whose result some used operand in ID needs: hold ID one cycle.
    assign w_stall = !rst && r_load && r_we && (|w_hit);

    // NOTE: the register array is cleared on reset because software may read a register before writing it.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_wb_write) begin
            r_regs[wb_waddr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_waddr <= '0;
            r_we    <= 1'b0;
            r_load  <= 1'b0;
        end else if (flush || w_stall) begin
            r_waddr <= '0;
            r_we    <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_rdata <= w_rdata;
            r_waddr <= id_waddr;
            r_we    <= id_we;
            r_load  <= id_is_load;
        end
    end

    assign rdata_ID_EXE = r_rdata;
    assign waddr_ID_EXE = r_waddr;
    assign we_ID_EXE    = r_we;
    assign load_ID_EXE  = r_load;
    assign stall        = w_stall;

`ifdef PIPE_REGFILE_PERF_CNT_EN
    logic [31:0]    r_fwd_count;
    logic [31:0]    r_stall_count;
    logic [NRP-1:0] w_fwd;
    logic [2:0]     w_fwd_num;
    logic [32:0]    w_fwd_sum;

    always_comb begin
        logic [AW-1:0] w_faddr;
        w_fwd     = '0;
        w_fwd_num = '0;
        w_faddr   = '0;
        for (int p = 0; p < NRP; p++) begin
            w_faddr  = raddr[p*AW +: AW];
            w_fwd[p] = !(w_zero_en && w_faddr == '0) &&
                       ((mem_we && mem_waddr == w_faddr) || (wb_we && wb_waddr == w_faddr));
            w_fwd_num = w_fwd_num + {2'b00, w_fwd[p]};
        end
    end

    assign w_fwd_sum = {1'b0, r_fwd_count} + 33'(w_fwd_num);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (!flush && !w_stall)
                r_fwd_count <= w_fwd_sum[32] ? 32'hFFFF_FFFF : w_fwd_sum[31:0];
            if (w_stall && r_stall_count != 32'hFFFF_FFFF)
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign fwd_count   = r_fwd_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_pipelined_regfile_fwd.sv
// Scoreboard bench for pipelined_regfile_fwd: directed test-plan cases plus random
// stimulus against a behavioural register-file/pipeline model.
module tb_pipelined_regfile_fwd;
    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam int NRP  = 2;
    localparam int AW   = 4;

    typedef struct packed {
        logic              rst;
        logic [NRP*AW-1:0] raddr;
        logic [NRP-1:0]    ren;
        logic [AW-1:0]     id_waddr;
        logic              id_we;
        logic              id_is_load;
        logic              flush;
        logic [AW-1:0]     mem_waddr;
        logic              mem_we;
        logic [DW-1:0]     mem_data;
        logic [AW-1:0]     wb_waddr;
        logic              wb_we;
        logic [DW-1:0]     wb_data;
    } stim_t;

    typedef struct packed {
        logic [NRP*DW-1:0] rdata;
        logic [AW-1:0]     waddr;
        logic              we;
        logic              load;
    } exe_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRP*AW-1:0] raddr;
    logic [NRP-1:0]    ren;
    logic [AW-1:0]     id_waddr;
    logic              id_we;
    logic              id_is_load;
    logic              flush;
    logic [AW-1:0]     mem_waddr;
    logic              mem_we;
    logic [DW-1:0]     mem_data;
    logic [AW-1:0]     wb_waddr;
    logic              wb_we;
    logic [DW-1:0]     wb_data;
    logic [NRP*DW-1:0] rdata_ID_EXE;
    logic [AW-1:0]     waddr_ID_EXE;
    logic              we_ID_EXE;
    logic              load_ID_EXE;
    logic              stall;
`ifdef PIPE_REGFILE_PERF_CNT_EN
    logic [31:0]       fwd_count;
    logic [31:0]       stall_count;
`endif

    pipelined_regfile_fwd dut (
        .clk(clk), .rst(rst), .raddr(raddr), .ren(ren),
        .id_waddr(id_waddr), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
        .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_data(mem_data),
        .wb_waddr(wb_waddr), .wb_we(wb_we), .wb_data(wb_data),
        .rdata_ID_EXE(rdata_ID_EXE), .waddr_ID_EXE(waddr_ID_EXE),
        .we_ID_EXE(we_ID_EXE), .load_ID_EXE(load_ID_EXE), .stall(stall)
`ifdef PIPE_REGFILE_PERF_CNT_EN
        , .fwd_count(fwd_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exe_t q_exe[$];
    logic q_stall[$];

    // Reference model: architectural registers and the ID/EXE latch contents.
    logic [DW-1:0]     m_regs [NREG];
    logic [NRP*DW-1:0] m_rdata = '0;
    logic [AW-1:0]     m_waddr = '0;
    logic              m_we    = 1'b0;
    logic              m_load  = 1'b0;
    longint            m_fwd_cnt   = 0;
    longint            m_stall_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input stim_t s, input logic [AW-1:0] a);
        if (a == '0)                         return '0;
        if (s.mem_we && s.mem_waddr == a)    return s.mem_data;
        if (s.wb_we && s.wb_waddr == a)      return s.wb_data;
        return m_regs[a];
    endfunction

    // Drive one cycle's inputs, predict stall now and the ID/EXE state after the edge.
    task automatic apply(input stim_t s);
        logic              st;
        logic [AW-1:0]     a;
        logic [NRP*DW-1:0] rd;
        int                nf;
        rst = s.rst; raddr = s.raddr; ren = s.ren;
        id_waddr = s.id_waddr; id_we = s.id_we; id_is_load = s.id_is_load; flush = s.flush;
        mem_waddr = s.mem_waddr; mem_we = s.mem_we; mem_data = s.mem_data;
        wb_waddr = s.wb_waddr; wb_we = s.wb_we; wb_data = s.wb_data;
        st = 1'b0;
        nf = 0;
        rd = '0;
        for (int p = 0; p < NRP; p++) begin
            a = s.raddr[p*AW +: AW];
            rd[p*DW +: DW] = ref_read(s, a);
            if (m_load && m_we && s.ren[p] && a == m_waddr && a != '0) st = 1'b1;
            if (a != '0 && ((s.mem_we && s.mem_waddr == a) || (s.wb_we && s.wb_waddr == a))) nf++;
        end
        if (s.rst) st = 1'b0;
        q_stall.push_back(st);
        if (s.rst) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            m_rdata = '0; m_waddr = '0; m_we = 1'b0; m_load = 1'b0;
            m_fwd_cnt = 0; m_stall_cnt = 0;
        end else begin
            if (s.flush || st) begin
                m_waddr = '0; m_we = 1'b0; m_load = 1'b0;
            end else begin
                m_rdata = rd; m_waddr = s.id_waddr; m_we = s.id_we; m_load = s.id_is_load;
                m_fwd_cnt += nf;
            end
            if (st) m_stall_cnt++;
            if (s.wb_we && s.wb_waddr != '0) m_regs[s.wb_waddr] = s.wb_data;
        end
        q_exe.push_back({m_rdata, m_waddr, m_we, m_load});
        @(negedge clk);
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s = '0;
        s.rst = ($urandom_range(0, 39) == 0);
        for (int p = 0; p < NRP; p++) s.raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
        s.ren        = NRP'($urandom);
        s.id_waddr   = AW'($urandom_range(0, 7));
        s.id_we      = 1'($urandom);
        s.id_is_load = s.id_we && ($urandom_range(0, 2) == 0);
        s.flush      = ($urandom_range(0, 7) == 0);
        s.mem_waddr  = AW'($urandom_range(0, 7));
        s.mem_we     = ($urandom_range(0, 2) == 0);
        s.mem_data   = DW'($urandom);
        s.wb_waddr   = AW'($urandom_range(0, 7));
        s.wb_we      = 1'($urandom);
        s.wb_data    = DW'($urandom);
        return s;
    endfunction

    // ID/EXE monitor: the latch is compared just after each rising edge.
    initial forever begin
        exe_t e;
        @(posedge clk);
        #1;
        if (q_exe.size() > 0) begin
            e = q_exe.pop_front();
            check("rdata_ID_EXE", 64'(rdata_ID_EXE), 64'(e.rdata));
            check("waddr_ID_EXE", 64'(waddr_ID_EXE), 64'(e.waddr));
            check("we_ID_EXE",    64'(we_ID_EXE),    64'(e.we));
            check("load_ID_EXE",  64'(load_ID_EXE),  64'(e.load));
        end
    end

    // Stall monitor: the combinational request is compared mid-cycle after inputs settle.
    initial forever begin
        logic st;
        @(negedge clk);
        #2;
        if (q_stall.size() > 0) begin
            st = q_stall.pop_front();
            check("stall", 64'(stall), 64'(st));
        end
    end

    initial begin
        stim_t s;
        int    guard;
        s = '0;
        rst = 1'b1; raddr = '0; ren = '0; id_waddr = '0; id_we = 1'b0; id_is_load = 1'b0;
        flush = 1'b0; mem_waddr = '0; mem_we = 1'b0; mem_data = '0;
        wb_waddr = '0; wb_we = 1'b0; wb_data = '0;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        @(negedge clk);

        // Reset clears a written register and the whole latch.
        s = '0; s.rst = 1'b1; apply(s); apply(s);
        s = '0; s.wb_we = 1'b1; s.wb_waddr = 4'd3; s.wb_data = 16'h1234; apply(s);
        s = '0; s.rst = 1'b1; s.id_we = 1'b1; s.id_waddr = 4'd9; apply(s);
        s = '0; s.raddr = {4'd3, 4'd3}; s.ren = 2'b11; apply(s);

        // Write-through on port 0.
        s = '0; s.wb_we = 1'b1; s.wb_waddr = 4'd5; s.wb_data = 16'hBEEF; s.raddr = {4'd1, 4'd5}; apply(s);

        // EXE/MEM beats MEM/WB on the same register, port 1.
        s = '0; s.mem_we = 1'b1; s.mem_waddr = 4'd2; s.mem_data = 16'h0011;
        s.wb_we = 1'b1; s.wb_waddr = 4'd2; s.wb_data = 16'h0022; s.raddr = {4'd2, 4'd0}; apply(s);

        // Load-use: stall one cycle with bubble, then the forwarded load result.
        s = '0; s.id_we = 1'b1; s.id_is_load = 1'b1; s.id_waddr = 4'd4; apply(s);
        s = '0; s.raddr = {4'd0, 4'd4}; s.ren = 2'b01; s.id_we = 1'b1; s.id_waddr = 4'd7; apply(s);
        s.mem_we = 1'b1; s.mem_waddr = 4'd4; s.mem_data = 16'h00AA; apply(s);

        // Zero register ignores writes and never causes a stall.
        s = '0; s.wb_we = 1'b1; s.wb_waddr = 4'd0; s.wb_data = 16'hFFFF;
        s.id_we = 1'b1; s.id_is_load = 1'b1; s.id_waddr = 4'd0; apply(s);
        s = '0; s.raddr = {4'd0, 4'd0}; s.ren = 2'b11; s.id_we = 1'b1; s.id_waddr = 4'd1; apply(s);

        // Flush together with stall: one bubble.
        s = '0; s.rst = 1'b1; apply(s);
        s = '0; s.id_we = 1'b1; s.id_is_load = 1'b1; s.id_waddr = 4'd6; apply(s);
        s = '0; s.raddr = {4'd6, 4'd0}; s.ren = 2'b10; s.flush = 1'b1; s.id_we = 1'b1; apply(s);
`ifdef PIPE_REGFILE_PERF_CNT_EN
        check("stall_count_flush", 64'(stall_count), 64'(m_stall_cnt));
`endif
        s = '0; apply(s);

        for (int n = 0; n < 600; n++) apply(rand_stim());

        s = '0; apply(s); apply(s);

        guard = 0;
        while ((q_exe.size() > 0 || q_stall.size() > 0) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (q_exe.size() > 0 || q_stall.size() > 0) begin
            bad++;
            $display("FAIL drain: exe_left=%0d stall_left=%0d expected 0", q_exe.size(), q_stall.size());
        end
        @(negedge clk);
`ifdef PIPE_REGFILE_PERF_CNT_EN
        check("fwd_count",   64'(fwd_count),   64'(m_fwd_cnt));
        check("stall_count", 64'(stall_count), 64'(m_stall_cnt));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
